div_req_ctrl: RTL
=================

Name: div_req_ctrl

Overview:
- Requesting side of the serial divider handshake. Accepts one division request from the issue stage, applies RV64 W-variant operand conditioning, and drives the divider's input handshake.
- Collects the divider's result, applies W-variant result sign-extension, and presents it to writeback through a one-entry result buffer.
- Sits between the issue/operand-read stage and the serial divider inside the mult/div unit; one request is outstanding at a time.

Parameters:
WIDTH, 64, datapath width; W-variants act on bits [31:0]; WIDTH >= 64.
TRANS_ID_BITS, ariane_pkg value, transaction-ID width.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  kill in-flight request and buffered result
req_valid_i  in  1  issue-stage request valid
req_ready_o  out  1  request accepted when valid&ready
req_id_i  in  TRANS_ID_BITS  transaction ID
req_op_i  in  2  0 udiv, 1 div, 2 urem, 3 rem
req_word_i  in  1  1 = W-variant (DIVW/DIVUW/REMW/REMUW)
req_a_i  in  WIDTH  dividend
req_b_i  in  WIDTH  divisor
div_vld_o  out  1  divider input valid
div_rdy_i  in  1  divider input ready
div_id_o  out  TRANS_ID_BITS  ID to divider
div_opcode_o  out  2  opcode to divider
div_op_a_o  out  WIDTH  conditioned dividend
div_op_b_o  out  WIDTH  conditioned divisor
div_flush_o  out  1  equals flush_i
div_out_vld_i  in  1  divider result valid
div_out_rdy_o  out  1  divider result accept
div_id_i  in  TRANS_ID_BITS  result ID
div_res_i  in  WIDTH  raw divider result
wb_valid_o  out  1  writeback valid
wb_ready_i  in  1  writeback accept
wb_id_o  out  TRANS_ID_BITS  writeback ID
wb_result_o  out  WIDTH  final result

Behaviour:
- Reset: state IDLE; all registers 0. req_ready_o=1; div_vld_o=0; div_out_rdy_o=0; wb_valid_o=0; wb_id_o=0; wb_result_o=0; div_id_o/div_opcode_o/div_op_a_o/div_op_b_o=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready_o=1 unless flush_i.
  - On accept, register the ID, the opcode, the word flag and both conditioned operands, then go to ISSUE.
- Operand conditioning (word=1):
  - Signed ops (op[0]=1): operand = sign-extension of bits [31:0].
  - Unsigned ops: operand = zero-extension of bits [31:0].
  - word=0: operands pass unchanged.
- ISSUE:
  - div_vld_o = div_rdy_i. Driven from registers, with no combinational path from req_* to div_*.
  - When div_vld_o=1, go to WAIT. The divider drops ready the cycle after, so div_vld_o is high for exactly one cycle per request.
  - While div_rdy_i=0, hold in ISSUE with operands stable.
- WAIT:
  - div_out_rdy_o=1.
  - On div_out_vld_i, capture the result and div_id_i, then go to RESP.
  - Result capture: word=1 gives the sign-extension of div_res_i[31:0] (both signed and unsigned W ops, per RV64); word=0 gives div_res_i.
- RESP:
  - wb_valid_o=1 with wb_id_o/wb_result_o stable.
  - On wb_ready_i, go to IDLE. A new request can be accepted the following cycle.
- Latency:
  - Request accepted at cycle 0; div_vld_o at cycle 1 at the earliest.
  - div_out_vld_i at cycle N gives wb_valid_o at N+1.
- div_out_rdy_o=0 in all states except WAIT.
- div_id_i is expected to equal the stored ID. A mismatch is flagged by a simulation assertion only; wb_id_o always takes div_id_i.
- flush_i, any state, highest priority:
  - Next state IDLE; req_ready_o, div_vld_o, div_out_rdy_o, wb_valid_o forced 0 that cycle.
  - A request or result presented in the flush cycle is dropped. Any buffered result is discarded.
  - div_flush_o=flush_i combinationally.
- Illegal state encoding: recover to IDLE.

Test Plan:
- DIV, word=0: a=100, b=7, op=1, id=5 → one-cycle div_vld_o with div_op_a_o=100, div_op_b_o=7; divider returns 14 → wb_valid_o one cycle later, wb_result_o=14, wb_id_o=5.
- DIVW: a=0xDEAD_BEEF_FFFF_FFF9, b=2, op=1, word=1 → div_op_a_o=0xFFFF_FFFF_FFFF_FFF9, div_op_b_o=2; divider returns 0xFFFF_FFFF_FFFF_FFFD → wb_result_o=0xFFFF_FFFF_FFFF_FFFD.
- DIVUW: a=0xFFFF_FFFF_8000_0000, b=1, op=0, word=1 → div_op_a_o=0x0000_0000_8000_0000; divider returns same value → wb_result_o=0xFFFF_FFFF_8000_0000.
- Backpressure on both sides:
  - div_rdy_i low for 3 cycles in ISSUE → div_vld_o stays 0, operands stable, then div_vld_o pulses once.
  - wb_ready_i low for 4 cycles → wb_valid_o and wb_result_o held, req_ready_o=0 throughout.
- Flush in WAIT coincident with div_out_vld_i → no wb_valid_o, div_flush_o=1 that cycle, req_ready_o=1 the next cycle.
- Flush in RESP → wb_valid_o drops next cycle; next request id=2, REM a=-7 (0xFFFF_FFFF_FFFF_FFF9), b=2 → div_opcode_o=3, wb_id_o=2.
- Reset asserted mid-ISSUE → all outputs return to reset values immediately.

Source files
------------

// File: rtl/div_req_ctrl.sv
// Request-side controller for the serial divider: conditions RV64 W-variant operands,
// issues one request at a time and buffers the sign-extended result for writeback.
module div_req_ctrl #(
  parameter int unsigned WIDTH         = 64,
  parameter int unsigned TRANS_ID_BITS = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [TRANS_ID_BITS-1:0] req_id_i,
  input  logic [1:0]               req_op_i,
  input  logic                     req_word_i,
  input  logic [WIDTH-1:0]         req_a_i,
  input  logic [WIDTH-1:0]         req_b_i,
  output logic                     div_vld_o,
  input  logic                     div_rdy_i,
  output logic [TRANS_ID_BITS-1:0] div_id_o,
  output logic [1:0]               div_opcode_o,
  output logic [WIDTH-1:0]         div_op_a_o,
  output logic [WIDTH-1:0]         div_op_b_o,
  output logic                     div_flush_o,
  input  logic                     div_out_vld_i,
  output logic                     div_out_rdy_o,
  input  logic [TRANS_ID_BITS-1:0] div_id_i,
  input  logic [WIDTH-1:0]         div_res_i,
  output logic                     wb_valid_o,
  input  logic                     wb_ready_i,
  output logic [TRANS_ID_BITS-1:0] wb_id_o,
  output logic [WIDTH-1:0]         wb_result_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e                   r_state;
  state_e                   w_next;
  logic [TRANS_ID_BITS-1:0] r_id;
  logic [1:0]               r_op;
  logic                     r_word;
  logic [WIDTH-1:0]         r_a;
  logic [WIDTH-1:0]         r_b;
  logic [TRANS_ID_BITS-1:0] r_wb_id;
  logic [WIDTH-1:0]         r_wb_res;

  logic                     w_accept;
  logic                     w_capture;
  logic [WIDTH-1:0]         w_a_cond;
  logic [WIDTH-1:0]         w_b_cond;
  logic [WIDTH-1:0]         w_res_ext;

  function automatic logic [WIDTH-1:0] cond_op(input logic [WIDTH-1:0] v,
                                               input logic word,
                                               input logic sgn);
    if (!word)
      return v;
    return sgn ? {{(WIDTH-32){v[31]}}, v[31:0]} : {{(WIDTH-32){1'b0}}, v[31:0]};
  endfunction

  assign w_a_cond  = cond_op(req_a_i, req_word_i, req_op_i[0]);
  assign w_b_cond  = cond_op(req_b_i, req_word_i, req_op_i[0]);
  // RV64 W results are always sign-extended from bit 31, even for the unsigned variants.
  assign w_res_ext = cond_op(div_res_i, r_word, 1'b1);

  assign w_accept  = req_valid_i & req_ready_o;
  assign w_capture = div_out_vld_i & div_out_rdy_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (flush_i) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (req_valid_i)   w_next = S_ISSUE;
        S_ISSUE: if (div_rdy_i)     w_next = S_WAIT;
        S_WAIT:  if (div_out_vld_i) w_next = S_RESP;
        S_RESP:  if (wb_ready_i)    w_next = S_IDLE;
        default:                    w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready_o   = 1'b0;
    div_vld_o     = 1'b0;
    div_out_rdy_o = 1'b0;
    wb_valid_o    = 1'b0;
    if (!flush_i) begin
      case (r_state)
        S_IDLE:  req_ready_o   = 1'b1;
        S_ISSUE: div_vld_o     = div_rdy_i;
        S_WAIT:  div_out_rdy_o = 1'b1;
        S_RESP:  wb_valid_o    = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_id     <= '0;
      r_op     <= '0;
      r_word   <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_wb_id  <= '0;
      r_wb_res <= '0;
    end else if (flush_i) begin
      r_wb_id  <= '0;
      r_wb_res <= '0;
    end else begin
      if (w_accept) begin
        r_id   <= req_id_i;
        r_op   <= req_op_i;
        r_word <= req_word_i;
        r_a    <= w_a_cond;
        r_b    <= w_b_cond;
      end
      if (w_capture) begin
        r_wb_id  <= div_id_i;
        r_wb_res <= w_res_ext;
      end
    end
  end

  assign div_id_o     = r_id;
  assign div_opcode_o = r_op;
  assign div_op_a_o   = r_a;
  assign div_op_b_o   = r_b;
  assign div_flush_o  = flush_i;
  assign wb_id_o      = r_wb_id;
  assign wb_result_o  = r_wb_res;

  a_id_match: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (r_state == S_WAIT && div_out_vld_i && !flush_i) |-> (div_id_i == r_id));

endmodule
